// File: rtl/exc_redirect_ctrl_pkg.sv
// rtl/exc_redirect_ctrl_pkg.sv - shared constants and state encoding for the redirect controller
package exc_redirect_ctrl_pkg;

    localparam logic [31:0] DEF_EXC_ENTRY = 32'hbfc00380;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DRAIN    = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

endpackage

// File: rtl/exc_redirect_ctrl.sv
// rtl/exc_redirect_ctrl.sv - exception/ERET flush and PC redirect with in-flight fetch drain
module exc_redirect_ctrl
    import exc_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_ENTRY = DEF_EXC_ENTRY,
    parameter int          MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        exception,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        inst_req,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        drop_data,
    output logic        busy
);

    localparam int CW = $clog2(MAX_OUTST + 1);

    state_t        state;
    logic [CW-1:0] outst;
    logic [CW-1:0] stale;
    logic [31:0]   target;

    logic          hs;
    logic          evt;
    logic          drop;
    logic [CW-1:0] hs_w;
    logic [CW-1:0] dok_w;
    logic [CW-1:0] drop_w;
    logic [CW-1:0] keep_w;
    logic [CW-1:0] stale_evt;
    logic [CW-1:0] stale_nxt;

    assign hs     = inst_req & inst_addr_ok;
    assign evt    = exception | eret;
    assign drop   = inst_data_ok & (stale != '0);
    assign hs_w   = CW'(hs);
    assign dok_w  = CW'(inst_data_ok);
    assign drop_w = CW'(drop);
    assign keep_w = CW'(inst_data_ok & ~drop);

    // Data returning in the event cycle belongs to the pre-flush stream.
    assign stale_evt = stale + outst + hs_w - dok_w;
    // Once an event is pending, every newly accepted request is already squashed.
    assign stale_nxt = stale - drop_w + ((state == S_IDLE) ? '0 : hs_w);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= S_IDLE;
            outst  <= '0;
            stale  <= '0;
            target <= EXC_ENTRY;
        end else if (evt) begin
            target <= exception ? EXC_ENTRY : epc;
            stale  <= stale_evt;
            outst  <= '0;
            state  <= (stale_evt != '0) ? S_DRAIN : S_REDIRECT;
        end else begin
            stale <= stale_nxt;
            if (state == S_IDLE) begin
                outst <= outst + hs_w - keep_w;
            end
            case (state)
                S_IDLE: ;
                S_DRAIN: begin
                    if (stale_nxt == '0) begin
                        state <= S_REDIRECT;
                    end
                end
                S_REDIRECT: begin
                    if (stale_nxt != '0) begin
                        state <= S_DRAIN;
                    end else if (redirect_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign flush          = evt;
    assign redirect_valid = (state == S_REDIRECT);
    assign redirect_pc    = target;
    assign drop_data      = drop;
    assign busy           = (state != S_IDLE);

    a_outst_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !(hs && (outst == CW'(MAX_OUTST))));

    a_spurious_data: assert property (@(posedge clk) disable iff (!resetn)
        !(inst_data_ok && (stale == '0) && (outst == '0)));

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// tb/tb_exc_redirect_ctrl.sv - vector table, reset corner and randomized model check for exc_redirect_ctrl
module tb_exc_redirect_ctrl;

    localparam logic [31:0] EXC = 32'hbfc00380;
    localparam logic [31:0] P1  = 32'hbfc00100;
    localparam logic [31:0] P2  = 32'hbfc00200;
    localparam int          MAX = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        exception = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] epc = '0;
    logic        inst_req = 1'b0;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic        redirect_ready = 1'b0;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        drop_data;
    logic        busy;
    logic [35:0] obs;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        exc, ert;
        logic [31:0] epc;
        logic        req, aok, dok, rdy;
        logic        fl, rv;
        logic [31:0] pc;
        logic        dr, bz;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    exc_redirect_ctrl dut (
        .clk            (clk),
        .resetn         (resetn),
        .exception      (exception),
        .eret           (eret),
        .epc            (epc),
        .inst_req       (inst_req),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .drop_data      (drop_data),
        .busy           (busy)
    );

    assign obs = {flush, redirect_valid, drop_data, busy, redirect_pc};

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got fl/rv/dr/bz=%b pc=%h, want fl/rv/dr/bz=%b pc=%h",
                     name, act[35:32], act[31:0], exp[35:32], exp[31:0]);
        end
    endtask

    task automatic drive(input logic a_exc, input logic a_ert, input logic [31:0] a_epc,
                         input logic a_req, input logic a_aok, input logic a_dok, input logic a_rdy);
        exception      = a_exc;
        eret           = a_ert;
        epc            = a_epc;
        inst_req       = a_req;
        inst_addr_ok   = a_aok;
        inst_data_ok   = a_dok;
        redirect_ready = a_rdy;
    endtask

    function automatic vec_t mk(logic exc, logic ert, logic [31:0] e, logic req, logic aok,
                                logic dok, logic rdy, logic fl, logic rv, logic [31:0] pc,
                                logic dr, logic bz);
        vec_t v;
        v.exc = exc; v.ert = ert; v.epc = e; v.req = req; v.aok = aok; v.dok = dok; v.rdy = rdy;
        v.fl = fl; v.rv = rv; v.pc = pc; v.dr = dr; v.bz = bz;
        return v;
    endfunction

    int          m_live, m_stale, hs;
    bit          m_owed, rv_e;
    logic [31:0] m_tgt;
    logic        r_exc, r_ert, r_req, r_aok, r_dok, r_rdy;
    logic [31:0] r_epc;

    initial begin
        // exception in IDLE with nothing outstanding
        tbl.push_back(mk(1, 0, 0,  0, 0, 0, 0,  1, 0, EXC, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0, 0,  0, 1, EXC, 0, 1));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0, 1,  0, 1, EXC, 0, 1));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0, 0,  0, 0, EXC, 0, 0));
        // eret with two outstanding requests
        tbl.push_back(mk(0, 0, 0,  1, 1, 0, 0,  0, 0, EXC, 0, 0));
        tbl.push_back(mk(0, 0, 0,  1, 1, 0, 0,  0, 0, EXC, 0, 0));
        tbl.push_back(mk(0, 1, P1, 0, 0, 0, 0,  1, 0, EXC, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0, 1, 0,  0, 0, P1,  1, 1));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0, 0,  0, 0, P1,  0, 1));
        tbl.push_back(mk(0, 0, 0,  0, 0, 1, 0,  0, 0, P1,  1, 1));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0, 0,  0, 1, P1,  0, 1));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0, 1,  0, 1, P1,  0, 1));
        // exception and eret together
        tbl.push_back(mk(1, 1, P1, 0, 0, 0, 0,  1, 0, P1,  0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0, 1,  0, 1, EXC, 0, 1));
        // handshake and data return in the event cycle
        tbl.push_back(mk(0, 0, 0,  1, 1, 0, 0,  0, 0, EXC, 0, 0));
        tbl.push_back(mk(1, 0, 0,  1, 1, 1, 0,  1, 0, EXC, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0, 1, 0,  0, 0, EXC, 1, 1));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0, 1,  0, 1, EXC, 0, 1));
        // interrupt while redirecting for eret
        tbl.push_back(mk(0, 1, P2, 0, 0, 0, 0,  1, 0, EXC, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0, 0,  0, 1, P2,  0, 1));
        tbl.push_back(mk(1, 0, 0,  0, 0, 0, 0,  1, 1, P2,  0, 1));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0, 0,  0, 1, EXC, 0, 1));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0, 1,  0, 1, EXC, 0, 1));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0, 0,  0, 0, EXC, 0, 0));
        // handshake while redirect is offered sends it back to drain
        tbl.push_back(mk(1, 0, 0,  0, 0, 0, 0,  1, 0, EXC, 0, 0));
        tbl.push_back(mk(0, 0, 0,  1, 1, 0, 1,  0, 1, EXC, 0, 1));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0, 0,  0, 0, EXC, 0, 1));
        tbl.push_back(mk(0, 0, 0,  0, 0, 1, 0,  0, 0, EXC, 1, 1));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0, 1,  0, 1, EXC, 0, 1));
        tbl.push_back(mk(0, 0, 0,  0, 0, 0, 0,  0, 0, EXC, 0, 0));

        repeat (2) @(negedge clk);
        #1 check("reset", obs, {4'b0000, EXC});
        @(negedge clk);
        resetn = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].exc, tbl[i].ert, tbl[i].epc, tbl[i].req, tbl[i].aok, tbl[i].dok, tbl[i].rdy);
            #1 check($sformatf("vec%0d", i), obs,
                     {tbl[i].fl, tbl[i].rv, tbl[i].dr, tbl[i].bz, tbl[i].pc});
        end

        // reset while draining two stale returns
        @(negedge clk); drive(0, 0, 0, 1, 1, 0, 0);
        @(negedge clk); drive(0, 0, 0, 1, 1, 0, 0);
        @(negedge clk); drive(0, 1, 32'h12345678, 0, 0, 0, 0);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0);
        #1 check("drain_busy", obs, {4'b0001, 32'h12345678});
        resetn = 1'b0;
        inst_data_ok = 1'b1;
        #1 check("reset_async", obs, {4'b0000, EXC});
        @(negedge clk);
        inst_data_ok = 1'b0;
        resetn = 1'b1;
        @(posedge clk);
        #1 inst_data_ok = 1'b1;
        #1 check("post_reset_drop", obs, {4'b0000, EXC});
        inst_data_ok = 1'b0;

        m_live = 0; m_stale = 0; m_owed = 0; m_tgt = EXC;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            r_exc = ($urandom_range(15) == 0);
            r_ert = ($urandom_range(15) == 0);
            r_epc = $urandom;
            r_req = 1'($urandom_range(1));
            r_aok = 1'($urandom_range(1));
            if (m_live + m_stale >= MAX) r_aok = 1'b0;
            r_dok = (m_live + m_stale > 0) && ($urandom_range(2) == 0);
            r_rdy = 1'($urandom_range(1));
            drive(r_exc, r_ert, r_epc, r_req, r_aok, r_dok, r_rdy);
            hs   = (r_req && r_aok) ? 1 : 0;
            rv_e = m_owed && (m_stale == 0);
            #1 check($sformatf("rand%0d", n), obs,
                     {r_exc | r_ert, rv_e, r_dok && (m_stale > 0), m_owed, m_tgt});
            if (r_exc || r_ert) begin
                m_stale = m_stale + m_live + hs - (r_dok ? 1 : 0);
                m_live  = 0;
                m_owed  = 1;
                m_tgt   = r_exc ? EXC : r_epc;
            end else begin
                if (r_dok) begin
                    if (m_stale > 0) m_stale--;
                    else m_live--;
                end
                if (hs != 0) begin
                    if (m_owed) m_stale++;
                    else m_live++;
                end
                if (rv_e && r_rdy && hs == 0) m_owed = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
